i_rotary_encoder: RTL and testbench

- Quadrature rotary-encoder decoder. Samples the two raw phase inputs on the system clock and tracks the Gray-code sequence.
- Emits one single-cycle count pulse, with a direction flag, for each complete, consistent detent cycle that starts and ends at phase 00.
- Incomplete, reversed-midway or glitchy sequences produce no pulse.
- Sits between the encoder pins and a position counter, which adds ±1 on each pulse.

---
 rtl/i_rotary_encoder.sv | 130 +++++++++++++
 tb/tb_i_rotary_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i_rotary_encoder.sv
// Quadrature rotary-encoder decoder: tracks the {B,A} Gray-code sequence and
// emits one registered count pulse plus direction for each full detent cycle.
module i_rotary_encoder (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_phase_a,
  input  logic i_phase_b,
  output logic o_cnt,
  output logic o_cnt_cw
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6,
    ST_WAIT = 3'd7
  } state_t;

  // Power-up values match the reset values so the block starts deterministic.
  state_t     state_q  = ST_IDLE;
  state_t     state_d;
  logic       cnt_q    = 1'b0;
  logic       cnt_d;
  logic       cnt_cw_q = 1'b0;
  logic       cnt_cw_d;
  logic [1:0] phase_s;

  assign phase_s = {i_phase_b, i_phase_a};

  always_comb begin
    state_d  = state_q;
    cnt_d    = 1'b0;
    cnt_cw_d = cnt_cw_q;
    unique case (state_q)
      ST_IDLE: begin
        case (phase_s)
          2'b01:   state_d = ST_CW1;
          2'b10:   state_d = ST_CCW1;
          2'b11:   state_d = ST_WAIT;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_CW1: begin
        case (phase_s)
          2'b11:   state_d = ST_CW2;
          2'b00:   state_d = ST_IDLE;
          2'b10:   state_d = ST_WAIT;
          default: state_d = ST_CW1;
        endcase
      end
      ST_CW2: begin
        case (phase_s)
          2'b10:   state_d = ST_CW3;
          2'b01:   state_d = ST_CW1;
          2'b00:   state_d = ST_WAIT;
          default: state_d = ST_CW2;
        endcase
      end
      ST_CW3: begin
        case (phase_s)
          2'b00: begin
            state_d  = ST_IDLE;
            cnt_d    = 1'b1;
            cnt_cw_d = 1'b1;
          end
          2'b11:   state_d = ST_CW2;
          2'b01:   state_d = ST_WAIT;
          default: state_d = ST_CW3;
        endcase
      end
      ST_CCW1: begin
        case (phase_s)
          2'b11:   state_d = ST_CCW2;
          2'b00:   state_d = ST_IDLE;
          2'b01:   state_d = ST_WAIT;
          default: state_d = ST_CCW1;
        endcase
      end
      ST_CCW2: begin
        case (phase_s)
          2'b01:   state_d = ST_CCW3;
          2'b10:   state_d = ST_CCW1;
          2'b00:   state_d = ST_WAIT;
          default: state_d = ST_CCW2;
        endcase
      end
      ST_CCW3: begin
        case (phase_s)
          2'b00: begin
            state_d  = ST_IDLE;
            cnt_d    = 1'b1;
            cnt_cw_d = 1'b0;
          end
          2'b11:   state_d = ST_CCW2;
          2'b10:   state_d = ST_WAIT;
          default: state_d = ST_CCW3;
        endcase
      end
      ST_WAIT: begin
        if (phase_s == 2'b00) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset wins over a completion sampled on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 1'b0;
      cnt_cw_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cnt_cw_q <= cnt_cw_d;
    end
  end

  assign o_cnt    = cnt_q;
  assign o_cnt_cw = cnt_cw_q;

endmodule

// File: tb/tb_i_rotary_encoder.sv
// Table-driven bench for i_rotary_encoder: per-cycle pulse/direction vectors,
// a downstream position counter, and an edge monitor over invalid sequences.
module tb_i_rotary_encoder;

  logic clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_phase_a = 1'b0;
  logic i_phase_b = 1'b0;
  logic o_cnt;
  logic o_cnt_cw;

  i_rotary_encoder dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_phase_a(i_phase_a),
    .i_phase_b(i_phase_b),
    .o_cnt    (o_cnt),
    .o_cnt_cw (o_cnt_cw)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit [1:0] p;
    bit       e_cnt;
    bit       e_cw;
    bit       chk_pos;
    bit [1:0] e_pos;
    bit       mon;
  } vec_t;

  vec_t     vq[$];
  bit       cur_mon  = 1'b0;
  bit       pend_chk = 1'b0;
  bit [1:0] pend_pos = 2'd0;
  int       tests_run = 0;
  int       tests_failed = 0;
  int       mon_edges = 0;
  bit       mon_en = 1'b0;
  logic [1:0] pos = 2'd0;

  // Position counter downstream of the decoder.
  always @(posedge clk) begin
    if (i_rst) pos <= 2'd0;
    else if (o_cnt) pos <= o_cnt_cw ? pos + 2'd1 : pos - 2'd1;
  end

  always @(o_cnt or o_cnt_cw) begin
    if (mon_en) mon_edges++;
  end

  task automatic add(input bit rst, input bit [1:0] p, input bit c, input bit cw);
    vec_t v;
    v.rst = rst; v.p = p; v.e_cnt = c; v.e_cw = cw;
    v.chk_pos = pend_chk; v.e_pos = pend_pos; v.mon = cur_mon;
    pend_chk = 1'b0;
    vq.push_back(v);
  endtask

  task automatic mark_pos(input bit [1:0] val);
    pend_chk = 1'b1;
    pend_pos = val;
  endtask

  // Four phases, each held for 'hold' clocks; the pulse lands on the first 00 clock.
  task automatic add_seq(input bit [7:0] s, input int hold, input bit cw_before,
                         input bit pulse, input bit cw_after);
    bit [1:0] ph;
    for (int i = 0; i < 4; i++) begin
      ph = s[2*(3-i) +: 2];
      for (int j = 0; j < hold; j++) begin
        if (i == 3 && pulse) add(1'b0, ph, (j == 0), cw_after);
        else add(1'b0, ph, 1'b0, cw_before);
      end
    end
  endtask

  task automatic add_inv(input bit [9:0] s, input int n);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < n; i++)
        add(1'b0, s[2*(n-1-i) +: 2], 1'b0, 1'b0);
  endtask

  initial begin
    vec_t v;
    // Power-up values before any reset edge.
    #2;
    tests_run++;
    if (o_cnt !== 1'b0 || o_cnt_cw !== 1'b0) begin
      tests_failed++;
      $display("FAIL powerup: got cnt=%b cw=%b, want cnt=0 cw=0", o_cnt, o_cnt_cw);
    end

    add(1'b1, 2'b00, 1'b0, 1'b0);
    add(1'b1, 2'b00, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0);
    // Fast CW x3, fast CCW x3
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 1, 1'b0, 1'b1, 1'b1);
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 1, 1'b1, 1'b1, 1'b1);
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 1, 1'b1, 1'b1, 1'b1);
    mark_pos(2'd3);
    add_seq({2'b10, 2'b11, 2'b01, 2'b00}, 1, 1'b1, 1'b1, 1'b0);
    add_seq({2'b10, 2'b11, 2'b01, 2'b00}, 1, 1'b0, 1'b1, 1'b0);
    add_seq({2'b10, 2'b11, 2'b01, 2'b00}, 1, 1'b0, 1'b1, 1'b0);
    mark_pos(2'd0);
    // Slow (10 clocks per phase)
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 10, 1'b0, 1'b1, 1'b1);
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 10, 1'b1, 1'b1, 1'b1);
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 10, 1'b1, 1'b1, 1'b1);
    mark_pos(2'd3);
    add_seq({2'b10, 2'b11, 2'b01, 2'b00}, 10, 1'b1, 1'b1, 1'b0);
    add_seq({2'b10, 2'b11, 2'b01, 2'b00}, 10, 1'b0, 1'b1, 1'b0);
    add_seq({2'b10, 2'b11, 2'b01, 2'b00}, 10, 1'b0, 1'b1, 1'b0);
    mark_pos(2'd0);
    // Invalid sequences: outputs must stay frozen
    cur_mon = 1'b1;
    add_inv({2'b00, 2'b01, 2'b00, 2'b10, 2'b00}, 4);
    add_inv({4'b0000, 2'b00, 2'b11, 2'b00}, 3);
    add_inv({2'b00, 2'b10, 2'b11, 2'b10, 2'b00}, 5);
    add_inv({2'b00, 2'b01, 2'b11, 2'b01, 2'b00}, 5);
    add_inv({2'b00, 2'b00, 2'b10, 2'b11, 2'b00}, 4);
    add_inv({2'b00, 2'b00, 2'b01, 2'b11, 2'b00}, 4);
    add(1'b0, 2'b00, 1'b0, 1'b0);
    cur_mon = 1'b0;
    // One valid CW, then reset while in CW3 with P=10
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 1, 1'b0, 1'b1, 1'b1);
    mark_pos(2'd1);
    add(1'b0, 2'b01, 1'b0, 1'b1);
    add(1'b0, 2'b11, 1'b0, 1'b1);
    add(1'b0, 2'b10, 1'b0, 1'b1);
    add(1'b1, 2'b10, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0);
    mark_pos(2'd0);
    add_seq({2'b01, 2'b11, 2'b10, 2'b00}, 1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 2'b00, 1'b0, 1'b1);
    mark_pos(2'd1);
    // Reset on the very edge that samples the completing 00
    add(1'b0, 2'b01, 1'b0, 1'b1);
    add(1'b0, 2'b11, 1'b0, 1'b1);
    add(1'b0, 2'b10, 1'b0, 1'b1);
    add(1'b1, 2'b00, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0);
    mark_pos(2'd0);
    add(1'b0, 2'b00, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    foreach (vq[k]) begin
      v = vq[k];
      i_rst = v.rst;
      {i_phase_b, i_phase_a} = v.p;
      mon_en = v.mon;
      @(posedge clk);
      #1;
      tests_run++;
      if (o_cnt !== v.e_cnt) begin
        tests_failed++;
        $display("FAIL o_cnt vec%0d: got %b, want %b", k, o_cnt, v.e_cnt);
      end
      tests_run++;
      if (o_cnt_cw !== v.e_cw) begin
        tests_failed++;
        $display("FAIL o_cnt_cw vec%0d: got %b, want %b", k, o_cnt_cw, v.e_cw);
      end
      if (v.chk_pos) begin
        tests_run++;
        if (pos !== v.e_pos) begin
          tests_failed++;
          $display("FAIL position vec%0d: got %0d, want %0d", k, pos, v.e_pos);
        end
      end
    end
    mon_en = 1'b0;

    tests_run++;
    if (mon_edges != 0) begin
      tests_failed++;
      $display("FAIL invalid_edges: got %0d output edges, want 0", mon_edges);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
